regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-read-port register file for the pipelined MIPS datapath. It is the next generation of the single-cycle register file, with configurable width, depth and read-port count, plus:
- an optional hardwired zero entry;
- write-to-read bypass;
- a per-entry pending-write scoreboard for hazard detection;
- a sequential bulk-clear engine.

It sits between decode (reads, issue marking) and writeback (writes).

Parameters:
DATA_W, 32, width of each register entry in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of independent read ports
ZERO_REG, 1, 1 = entry 0 always reads 0, ignores writes, never pending
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
rd_addr  in  NUM_RD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data; port i uses bits [i*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  per-port flag: addressed entry has an outstanding producer
wr_en  in  1  writeback enable
wr_addr  in  ADDR_W  writeback address
wr_data  in  DATA_W  writeback data
iss_en  in  1  issue: mark iss_addr as pending
iss_addr  in  ADDR_W  destination register of the issued instruction
clr_req  in  1  start bulk clear (sampled in IDLE only)
clr_busy  out  1  high while the clear engine runs
clr_done  out  1  one-cycle pulse when the clear completes

Behaviour:
Reset and clock
- Single clock clk; reset rst_n is asynchronous, active-low.
- While rst_n=0: all entries = 0, all pending bits = 0, FSM = IDLE, clr_ptr = 0, clr_busy = 0, clr_done = 0. rd_data follows the (zeroed) array; rd_busy = 0.

Read path (combinational, zero latency)
- rd_data[i] = array[rd_addr[i]].
- ZERO_REG=1 and rd_addr[i]=0 -> rd_data[i] = 0 regardless of any other condition.
- BYPASS=1, FSM=IDLE, wr_en=1, wr_addr=rd_addr[i], and address is not the zero entry -> rd_data[i] = wr_data.

Write path
- Write happens at posedge when wr_en=1 and FSM=IDLE.
- Write to entry 0 is dropped when ZERO_REG=1.
- With one write port there are no write-write conflicts.

Scoreboard: pend[DEPTH]
- At posedge in IDLE:
  - wr_en clears pend[wr_addr].
  - iss_en sets pend[iss_addr].
  - Both to the same address in one cycle: set wins (a new producer supersedes).
- pend[0] is held 0 when ZERO_REG=1.
- rd_busy[i] = pend[rd_addr[i]], except it is forced to 0 when BYPASS=1, FSM=IDLE, wr_en=1 and wr_addr=rd_addr[i] (the value is forwarded this cycle).

Clear FSM: IDLE -> CLEAR -> DONE -> IDLE
- IDLE: clr_req=1 -> go to CLEAR, clr_ptr <= 0, all pend bits <= 0.
- CLEAR:
  - each cycle array[clr_ptr] <= 0 and clr_ptr increments;
  - at clr_ptr = DEPTH-1, write the last entry and go to DONE;
  - clr_busy = 1 throughout;
  - runs exactly DEPTH cycles.
- DONE: clr_done = 1 for exactly one cycle, clr_busy = 0, then go to IDLE.
- Outside IDLE:
  - wr_en and iss_en are ignored and have no state effect;
  - clr_req is ignored;
  - reads return the stored, partially cleared contents with bypass disabled.
- clr_req held high in IDLE after DONE starts a new clear.
- clr_ptr wraps naturally; it is not used outside CLEAR.
- Reset mid-clear: immediate return to IDLE with everything zeroed.

Arithmetic
- No arithmetic on data.
- Address comparisons are full ADDR_W equality.
- clr_ptr is ADDR_W bits.

Test Plan:
1. Reset and write/read: release rst_n, write 0xDEADBEEF to r9, next cycle read r9 on ports 0 and 1 -> both 0xDEADBEEF. Write 0x12345678 to r0 -> r0 reads 0.
2. Bypass: in one cycle wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5, rd_addr[0]=7 -> rd_data[0] = 0xA5A5A5A5 combinationally, rd_busy[0]=0. With BYPASS=0 -> old value returned.
3. Scoreboard:
   - iss_en for r5 -> rd_busy=1 on reads of r5 from the next cycle.
   - writeback r5 -> busy clears.
   - iss_en and wr_en both targeting r5 in one cycle -> r5 stays pending, data written.
4. Bulk clear (DEPTH=32): fill r1..r31 with nonzero values, pulse clr_req ->
   - clr_busy high for exactly 32 cycles;
   - clr_done pulses one cycle later;
   - all entries and pend bits read 0;
   - wr_en to r3 during CLEAR is ignored (r3 = 0 afterwards).
5. Reset mid-clear: assert rst_n=0 at clear cycle 10 -> clr_busy drops immediately, FSM in IDLE, all entries 0, no clr_done.
6. Parameter sweep: DATA_W=16, ADDR_W=3, NUM_RD=4, ZERO_REG=0 -> r0 writable (write 0x00FF, read 0x00FF), four ports read distinct entries concurrently, clear takes 8 cycles.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional zero entry, write-to-read bypass,
// per-entry pending-write scoreboard and a sequential bulk-clear engine.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);
    localparam bit BYP_EN  = (BYPASS != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CLEAR = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic [DEPTH-1:0]    pend_q, pend_d;
    logic                clr_busy_q, clr_busy_d;
    logic                clr_done_q, clr_done_d;
    logic                idle_s;
    logic                wr_zero_s;

    assign idle_s    = (state_q == ST_IDLE);
    assign wr_zero_s = ZERO_EN && (wr_addr == {ADDR_W{1'b0}});
    assign clr_busy  = clr_busy_q;
    assign clr_done  = clr_done_q;

    // Clear sequencer next-state and pointer.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = {ADDR_W{1'b0}};
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                clr_ptr_d = clr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (clr_ptr_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                clr_ptr_d = {ADDR_W{1'b0}};
            end
        endcase
        clr_busy_d = (state_d == ST_CLEAR);
        clr_done_d = (state_d == ST_DONE);
    end

    // Array update: writeback in IDLE, one entry zeroed per cycle in CLEAR.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            mem_d[j] = mem_q[j];
        end
        if (idle_s) begin
            if (wr_en && !wr_zero_s) begin
                mem_d[wr_addr] = wr_data;
            end else begin
                mem_d[wr_addr] = mem_q[wr_addr];
            end
        end else if (state_q == ST_CLEAR) begin
            mem_d[clr_ptr_q] = {DATA_W{1'b0}};
        end else begin
            mem_d[clr_ptr_q] = mem_q[clr_ptr_q];
        end
    end

    // Scoreboard: issue after writeback so a same-address issue stays pending.
    always_comb begin
        pend_d = pend_q;
        if (idle_s) begin
            if (clr_req) begin
                pend_d = {DEPTH{1'b0}};
            end else begin
                if (wr_en) begin
                    pend_d[wr_addr] = 1'b0;
                end else begin
                    pend_d[wr_addr] = pend_q[wr_addr];
                end
                if (iss_en) begin
                    pend_d[iss_addr] = 1'b1;
                end else begin
                    pend_d[iss_addr] = pend_d[iss_addr];
                end
            end
        end else begin
            pend_d = pend_q;
        end
        if (ZERO_EN) begin
            pend_d[0] = 1'b0;
        end else begin
            pend_d[0] = pend_d[0];
        end
    end

    // State, scoreboard and array registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            clr_ptr_q  <= {ADDR_W{1'b0}};
            pend_q     <= {DEPTH{1'b0}};
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                mem_q[j] <= {DATA_W{1'b0}};
            end
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            pend_q     <= pend_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
            for (int j = 0; j < DEPTH; j++) begin
                mem_q[j] <= mem_d[j];
            end
        end
    end

    // Read ports: zero entry beats bypass, bypass only while IDLE.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic              zero_s;
        logic              fwd_s;

        assign addr_s = rd_addr[i*ADDR_W +: ADDR_W];
        assign zero_s = ZERO_EN && (addr_s == {ADDR_W{1'b0}});
        assign fwd_s  = BYP_EN && idle_s && wr_en && (wr_addr == addr_s) && !zero_s;

        assign rd_data[i*DATA_W +: DATA_W] = zero_s ? {DATA_W{1'b0}} :
                                             (fwd_s ? wr_data : mem_q[addr_s]);
        assign rd_busy[i] = fwd_s ? 1'b0 : pend_q[addr_s];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: default config, a no-bypass
// twin sharing its inputs, and a small 16-bit / 8-entry / 4-port config.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [9:0]  rd_addr;
    logic [63:0] rd_data, nb_rd_data;
    logic [1:0]  rd_busy, nb_rd_busy;
    logic        wr_en, iss_en, clr_req;
    logic [4:0]  wr_addr, iss_addr;
    logic [31:0] wr_data;
    logic        clr_busy, clr_done, nb_clr_busy, nb_clr_done;

    logic [11:0] p_rd_addr;
    logic [63:0] p_rd_data;
    logic [3:0]  p_rd_busy;
    logic        p_wr_en, p_iss_en, p_clr_req;
    logic [2:0]  p_wr_addr, p_iss_addr;
    logic [15:0] p_wr_data;
    logic        p_clr_busy, p_clr_done;

    int total = 0;
    int bad   = 0;
    int cnt;
    logic [15:0] pv [4];

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .clr_req(clr_req),
        .clr_busy(clr_busy), .clr_done(clr_done)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(nb_rd_data),
        .rd_busy(nb_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .clr_req(clr_req),
        .clr_busy(nb_clr_busy), .clr_done(nb_clr_done)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0), .BYPASS(1)) dut_p (
        .clk(clk), .rst_n(rst_n), .rd_addr(p_rd_addr), .rd_data(p_rd_data),
        .rd_busy(p_rd_busy), .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
        .iss_en(p_iss_en), .iss_addr(p_iss_addr), .clr_req(p_clr_req),
        .clr_busy(p_clr_busy), .clr_done(p_clr_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        rd_addr = 10'd0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
        iss_en = 1'b0; iss_addr = 5'd0; clr_req = 1'b0;
        p_rd_addr = 12'd0; p_wr_en = 1'b0; p_wr_addr = 3'd0; p_wr_data = 16'd0;
        p_iss_en = 1'b0; p_iss_addr = 3'd0; p_clr_req = 1'b0;

        // reset state
        #2;
        rd_addr = {5'd9, 5'd3};
        #1;
        chk("rst_rd_data", rd_data[31:0], 32'h0);
        chk("rst_rd_busy", {30'd0, rd_busy}, 32'h0);
        chk("rst_clr_busy", {31'd0, clr_busy}, 32'h0);
        chk("rst_clr_done", {31'd0, clr_done}, 32'h0);
        #9;
        rst_n = 1'b1;
        tick();

        // write / read, zero entry
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 1'b0; rd_addr = {5'd9, 5'd9};
        #1;
        chk("r9_port0", rd_data[31:0], 32'hDEADBEEF);
        chk("r9_port1", rd_data[63:32], 32'hDEADBEEF);
        chk("r9_nb", nb_rd_data[31:0], 32'hDEADBEEF);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678; rd_addr = {5'd0, 5'd0};
        #1;
        chk("r0_no_bypass", rd_data[31:0], 32'h0);
        tick();
        wr_en = 1'b0;
        #1;
        chk("r0_after_wr", rd_data[63:32], 32'h0);

        // write and issue same address: set wins, data written
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11111111;
        iss_en = 1'b1; iss_addr = 5'd7;
        tick();
        wr_en = 1'b0; iss_en = 1'b0; rd_addr = {5'd0, 5'd7};
        #1;
        chk("r7_data", rd_data[31:0], 32'h11111111);
        chk("r7_pending", {31'd0, rd_busy[0]}, 32'h1);

        // bypass vs no bypass
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        #1;
        chk("byp_data", rd_data[31:0], 32'hA5A5A5A5);
        chk("byp_busy", {31'd0, rd_busy[0]}, 32'h0);
        chk("nobyp_data", nb_rd_data[31:0], 32'h11111111);
        chk("nobyp_busy", {31'd0, nb_rd_busy[0]}, 32'h1);
        tick();
        wr_en = 1'b0;
        #1;
        chk("r7_after_wb", rd_data[31:0], 32'hA5A5A5A5);
        chk("r7_busy_clr", {31'd0, rd_busy[0]}, 32'h0);
        chk("r7_nb_busy_clr", {31'd0, nb_rd_busy[0]}, 32'h0);

        // scoreboard on r5
        iss_en = 1'b1; iss_addr = 5'd5; rd_addr = {5'd5, 5'd7};
        #1;
        chk("r5_busy_same_cyc", {31'd0, rd_busy[1]}, 32'h0);
        tick();
        iss_en = 1'b0;
        #1;
        chk("r5_busy", {31'd0, rd_busy[1]}, 32'h1);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h00000055;
        #1;
        chk("r5_fwd_busy", {31'd0, rd_busy[1]}, 32'h0);
        chk("r5_nb_busy", {31'd0, nb_rd_busy[1]}, 32'h1);
        tick();
        wr_en = 1'b0;
        #1;
        chk("r5_busy_done", {31'd0, rd_busy[1]}, 32'h0);
        chk("r5_data", rd_data[63:32], 32'h00000055);

        // bulk clear
        for (int j = 1; j < 32; j++) begin
            wr_en = 1'b1; wr_addr = 5'(j); wr_data = 32'h100 + 32'(j);
            tick();
        end
        wr_en = 1'b0; iss_en = 1'b1; iss_addr = 5'd10;
        tick();
        iss_en = 1'b0; rd_addr = {5'd20, 5'd10};
        #1;
        chk("r10_busy_pre", {31'd0, rd_busy[0]}, 32'h1);
        chk("r20_fill", rd_data[63:32], 32'h114);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        cnt = 0;
        while (clr_busy === 1'b1 && cnt < 100) begin
            cnt++;
            wr_en = (cnt == 5); iss_en = (cnt == 5);
            wr_addr = 5'd3; wr_data = 32'hFFFFFFFF; iss_addr = 5'd12;
            if (cnt == 5) begin
                rd_addr = {5'd20, 5'd3};
                #1;
                chk("clr_mid_r3", rd_data[31:0], 32'h0);
                chk("clr_mid_r20", rd_data[63:32], 32'h114);
                chk("clr_mid_busy", {30'd0, rd_busy}, 32'h0);
            end
            tick();
        end
        wr_en = 1'b0; iss_en = 1'b0;
        chk("clr_cycles", cnt, 32'd32);
        chk("clr_done_pulse", {31'd0, clr_done}, 32'h1);
        tick();
        chk("clr_done_end", {31'd0, clr_done}, 32'h0);
        chk("clr_busy_end", {31'd0, clr_busy}, 32'h0);
        for (int j = 0; j < 32; j++) begin
            rd_addr = {5'(j), 5'(j)};
            #1;
            chk("clr_entry", rd_data[31:0], 32'h0);
            chk("clr_pend", {30'd0, rd_busy}, 32'h0);
        end

        // reset in the middle of a clear
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h22;
        tick();
        wr_addr = 5'd30; wr_data = 32'h30;
        tick();
        wr_en = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (9) tick();
        #1;
        chk("mid_clr_busy", {31'd0, clr_busy}, 32'h1);
        rst_n = 1'b0; rd_addr = {5'd30, 5'd2};
        #1;
        chk("rst_mid_busy", {31'd0, clr_busy}, 32'h0);
        chk("rst_mid_done", {31'd0, clr_done}, 32'h0);
        chk("rst_mid_r30", rd_data[63:32], 32'h0);
        chk("rst_mid_r2", rd_data[31:0], 32'h0);
        #2;
        rst_n = 1'b1;
        repeat (2) begin
            tick();
            chk("post_rst_done", {31'd0, clr_done}, 32'h0);
            chk("post_rst_busy", {31'd0, clr_busy}, 32'h0);
        end
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
        tick();
        wr_en = 1'b0; rd_addr = {5'd30, 5'd4};
        #1;
        chk("post_rst_wr", rd_data[31:0], 32'h44);
        chk("post_rst_r30", rd_data[63:32], 32'h0);

        // small configuration: r0 writable, four concurrent ports, 8-cycle clear
        pv[0] = 16'h00FF; pv[1] = 16'h1111; pv[2] = 16'h2222; pv[3] = 16'h3333;
        for (int j = 0; j < 4; j++) begin
            p_wr_en = 1'b1; p_wr_addr = 3'(j); p_wr_data = pv[j];
            tick();
        end
        p_wr_en = 1'b0; p_rd_addr = {3'd0, 3'd1, 3'd2, 3'd3};
        #1;
        chk("p_port0_r3", {16'd0, p_rd_data[15:0]}, 32'h3333);
        chk("p_port1_r2", {16'd0, p_rd_data[31:16]}, 32'h2222);
        chk("p_port2_r1", {16'd0, p_rd_data[47:32]}, 32'h1111);
        chk("p_port3_r0", {16'd0, p_rd_data[63:48]}, 32'h00FF);
        p_iss_en = 1'b1; p_iss_addr = 3'd0;
        tick();
        p_iss_en = 1'b0;
        #1;
        chk("p_r0_pending", {28'd0, p_rd_busy}, 32'h8);
        p_clr_req = 1'b1;
        tick();
        p_clr_req = 1'b0;
        cnt = 0;
        while (p_clr_busy === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        chk("p_clr_cycles", cnt, 32'd8);
        chk("p_clr_done", {31'd0, p_clr_done}, 32'h1);
        tick();
        chk("p_r0_cleared", {16'd0, p_rd_data[63:48]}, 32'h0);
        chk("p_busy_cleared", {28'd0, p_rd_busy}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
